ghost_mode_ctrl: RTL and testbench

GHOST_MODE_CTRL -- requirements
Module: ghost_mode_ctrl

---
 rtl/ghost_mode_ctrl.sv | 147 ++++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_ctrl.sv
// Ghost mode scheduler: scatter/chase timetable, frightened override, reverse pulses.
// All outputs registered (1-cycle latency from inputs); enable=0 freezes everything, no backpressure.
module ghost_mode_ctrl #(
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int FRIGHT_SECS   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       powerPellet,
    output logic       isScatter,
    output logic       isChase,
    output logic       isFrightened,
    output logic       frightFlash,
    output logic       reverseDir,
    output logic [2:0] phase
);

    localparam int PW     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int FW_RAW = $clog2(FRIGHT_SECS + 1);
    localparam int FW     = (FW_RAW < 2) ? 2 : FW_RAW;

    localparam logic [PW-1:0] PRESC_MAX   = PW'(TICKS_PER_SEC - 1);
    localparam logic [FW-1:0] FRIGHT_LOAD = FW'(FRIGHT_SECS);
    localparam logic [FW-1:0] FLASH_LIM   = FW'(2);
    localparam logic [2:0]    LAST_PHASE  = 3'd7;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FRIGHT = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_presc, w_presc_nxt;
    logic [4:0]    r_secs,  w_secs_nxt;
    logic [FW-1:0] r_fcnt,  w_fcnt_nxt;
    logic [2:0]    r_phase, w_phase_nxt;
    logic          r_scatter, r_chase, r_fright, r_flash, r_rev;
    logic          w_scatter_nxt, w_chase_nxt, w_fright_nxt, w_flash_nxt, w_rev_nxt;
    logic          w_sec_tick;
    logic          w_pellet;
    logic [4:0]    w_dur;

    function automatic logic [4:0] phase_dur(input logic [2:0] p);
        case (p)
            3'd0:    phase_dur = 5'd7;
            3'd1:    phase_dur = 5'd20;
            3'd2:    phase_dur = 5'd7;
            3'd3:    phase_dur = 5'd20;
            3'd4:    phase_dur = 5'd5;
            3'd5:    phase_dur = 5'd20;
            3'd6:    phase_dur = 5'd5;
            default: phase_dur = 5'd0;
        endcase
    endfunction

    assign w_sec_tick = enable && (r_presc == PRESC_MAX);
    assign w_pellet   = enable && powerPellet;
    assign w_dur      = phase_dur(r_phase);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_secs_nxt  = r_secs;
        w_fcnt_nxt  = r_fcnt;
        w_phase_nxt = r_phase;
        w_rev_nxt   = 1'b0;

        if (enable) begin
            w_presc_nxt = w_sec_tick ? '0 : r_presc + PW'(1);
        end

        case (r_state)
            ST_NORMAL: begin
                if (w_sec_tick && (r_phase != LAST_PHASE)) begin
                    if (r_secs == w_dur - 5'd1) begin
                        w_phase_nxt = r_phase + 3'd1;
                        w_secs_nxt  = '0;
                        w_rev_nxt   = 1'b1;
                    end else begin
                        w_secs_nxt = r_secs + 5'd1;
                    end
                end
                // Clearing the prescaler drops the partial second of the phase.
                if (w_pellet) begin
                    w_state_nxt = ST_FRIGHT;
                    w_fcnt_nxt  = FRIGHT_LOAD;
                    w_presc_nxt = '0;
                    w_rev_nxt   = 1'b1;
                end
            end
            ST_FRIGHT: begin
                if (w_pellet) begin
                    w_fcnt_nxt  = FRIGHT_LOAD;
                    w_presc_nxt = '0;
                end else if (w_sec_tick) begin
                    w_fcnt_nxt = r_fcnt - FW'(1);
                    if (r_fcnt == FW'(1)) begin
                        w_state_nxt = ST_NORMAL;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_NORMAL;
            end
        endcase

        w_fright_nxt  = (w_state_nxt == ST_FRIGHT);
        w_scatter_nxt = !w_fright_nxt && !w_phase_nxt[0];
        w_chase_nxt   = !w_fright_nxt &&  w_phase_nxt[0];
        w_flash_nxt   = w_fright_nxt && (w_fcnt_nxt <= FLASH_LIM);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_NORMAL;
            r_presc   <= '0;
            r_secs    <= '0;
            r_fcnt    <= '0;
            r_phase   <= '0;
            r_scatter <= 1'b1;
            r_chase   <= 1'b0;
            r_fright  <= 1'b0;
            r_flash   <= 1'b0;
            r_rev     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_secs    <= w_secs_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_phase   <= w_phase_nxt;
            r_scatter <= w_scatter_nxt;
            r_chase   <= w_chase_nxt;
            r_fright  <= w_fright_nxt;
            r_flash   <= w_flash_nxt;
            r_rev     <= w_rev_nxt;
        end
    end

    assign isScatter    = r_scatter;
    assign isChase      = r_chase;
    assign isFrightened = r_fright;
    assign frightFlash  = r_flash;
    assign reverseDir   = r_rev;
    assign phase        = r_phase;

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Bench for ghost_mode_ctrl: cycle-count reference model checked every cycle plus directed scenarios.
module tb_ghost_mode_ctrl;

    localparam int T = 4;
    localparam int F = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       powerPellet = 1'b0;
    logic       isScatter, isChase, isFrightened, frightFlash, reverseDir;
    logic [2:0] phase;
    logic [7:0] act;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ghost_mode_ctrl #(.TICKS_PER_SEC(T), .FRIGHT_SECS(F)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .powerPellet  (powerPellet),
        .isScatter    (isScatter),
        .isChase      (isChase),
        .isFrightened (isFrightened),
        .frightFlash  (frightFlash),
        .reverseDir   (reverseDir),
        .phase        (phase)
    );

    assign act = {phase, isScatter, isChase, isFrightened, frightFlash, reverseDir};

    task automatic check(input string name, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model in terms of elapsed enabled cycles in the phase and fright cycles left.
    typedef struct packed {
        int   ph;
        int   cy;
        logic fr;
        int   lf;
        logic rv;
    } mdl_t;

    function automatic int dur_secs(input int p);
        case (p)
            0: return 7;
            1: return 20;
            2: return 7;
            3: return 20;
            4: return 5;
            5: return 20;
            6: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input logic en, input logic pel);
        mdl_t n;
        n = m;
        n.rv = 1'b0;
        if (!en) return n;
        if (m.fr) begin
            if (pel) begin
                n.lf = F * T;
            end else begin
                n.lf = m.lf - 1;
                if (n.lf == 0) n.fr = 1'b0;
            end
        end else begin
            if (m.ph < 7) begin
                n.cy = m.cy + 1;
                if (n.cy == dur_secs(m.ph) * T) begin
                    n.ph = m.ph + 1;
                    n.cy = 0;
                    n.rv = 1'b1;
                end
            end
            if (pel) begin
                n.cy = (n.cy / T) * T;
                n.fr = 1'b1;
                n.lf = F * T;
                n.rv = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] mexp(input mdl_t s);
        return {s.ph[2:0], !s.fr && !s.ph[0], !s.fr && s.ph[0], s.fr,
                s.fr && (s.lf <= 2 * T), s.rv};
    endfunction

    mdl_t m;

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= mstep(m, enable, powerPellet);
    end

    always @(negedge clk) begin
        if (reset) begin
            check("cycle_outputs", int'(act), int'(mexp(m)));
            check("one_hot_mode", $countones({isScatter, isChase, isFrightened}), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b1;
        powerPellet = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    task automatic edges_until_chase(output int n);
        n = 0;
        while (!isChase && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic pellet_pulse();
        powerPellet = 1'b1;
        step();
        powerPellet = 1'b0;
    endtask

    int n, cnt_a, cnt_b, cnt_c;
    logic [7:0] snap;

    initial begin
        // Reset values while held in reset
        reset = 1'b0;
        #12;
        check("reset_outputs", int'(act), 8'h10);

        // Release with enable: 28 cycles of scatter then phase 1
        do_reset();
        check("post_release_scatter", int'(act), 8'h10);
        edges_until_chase(n);
        check("release_to_chase_cycles", n, 28);
        check("phase_at_first_advance", int'(phase), 1);
        check("rev_at_first_advance", int'(reverseDir), 1);
        step();
        check("rev_one_cycle_only", int'(reverseDir), 0);

        // Whole schedule
        do_reset();
        n = 0;
        cnt_a = 0;
        while (phase != 3'd7 && n < 1000) begin
            step();
            n++;
            cnt_a += int'(reverseDir);
        end
        check("cycles_to_phase7", n, 336);
        check("schedule_rev_pulses", cnt_a, 7);
        check("model_phase7_pin", m.ph, 7);
        cnt_b = 0;
        repeat (400) begin
            step();
            if (!isChase || reverseDir || phase != 3'd7) cnt_b++;
        end
        check("phase7_hold_violations", cnt_b, 0);

        // Pellet at cycle 10 of phase 0
        do_reset();
        repeat (10) step();
        pellet_pulse();
        check("fright_entry", int'(isFrightened), 1);
        check("fright_entry_rev", int'(reverseDir), 1);
        cnt_a = 0;
        cnt_b = 0;
        cnt_c = 0;
        while (isFrightened && cnt_a < 100) begin
            cnt_a++;
            cnt_b += int'(frightFlash);
            cnt_c += int'(reverseDir);
            step();
        end
        check("fright_cycles", cnt_a, 24);
        check("flash_cycles", cnt_b, 8);
        check("fright_rev_pulses", cnt_c, 1);
        check("exit_no_rev", int'(reverseDir), 0);
        cnt_a = 0;
        n = 0;
        while (phase == 3'd0 && n < 100) begin
            cnt_a += int'(isScatter);
            n++;
            step();
        end
        check("scatter_after_fright", cnt_a, 20);
        check("phase_after_fright", int'(phase), 1);

        // Second pellet 12 cycles into fright
        do_reset();
        repeat (10) step();
        pellet_pulse();
        repeat (11) step();
        pellet_pulse();
        cnt_a = 0;
        cnt_c = 0;
        while (isFrightened && cnt_a < 100) begin
            cnt_a++;
            cnt_c += int'(reverseDir);
            step();
        end
        check("refright_cycles", cnt_a, 24);
        check("refright_rev_pulses", cnt_c, 0);

        // Enable low for 50 cycles mid-phase with a pellet in the window
        do_reset();
        repeat (15) step();
        snap = act;
        enable = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) powerPellet = 1'b1;
            step();
            powerPellet = 1'b0;
            if (act != snap) cnt_a++;
        end
        check("frozen_output_changes", cnt_a, 0);
        enable = 1'b1;
        n = 0;
        while (phase == 3'd0 && n < 200) begin
            step();
            n++;
        end
        check("remaining_phase_cycles", n, 13);

        // Asynchronous reset mid-fright
        do_reset();
        repeat (3) step();
        pellet_pulse();
        repeat (5) step();
        check("pre_reset_frightened", int'(isFrightened), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", int'(act), 8'h10);
        @(posedge clk);
        #3;
        reset = 1'b1;
        edges_until_chase(n);
        check("rerelease_to_chase_cycles", n, 28);
        check("rerelease_rev", int'(reverseDir), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
